rvh_l1d_st_req_queue: RTL

//  In-order store-request queue between the LSU store pipe and rvh_l1d_amo_ctrl.

---
 rtl/rvh_l1d_st_req_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/rvh_l1d_st_req_queue.sv
// rvh_l1d_st_req_queue
//   In-order store/fence/AMO request queue between the LSU store pipe and
//   rvh_l1d_amo_ctrl. Accepts one request per cycle and presents the two oldest
//   entries: head on port 0, head+1 on port 1. Fences and AMOs issue only from
//   port 0, and younger entries never overtake them.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  squash all entries (drops a same-cycle enqueue)
//   lsu_st_req_*_i / _rdy_o  enqueue side
//   st_req_*_o / st_req_rdy_i per-port dequeue side, port p at [p*W +: W]
//   st_req_queue_empty_o     no valid entries
module rvh_l1d_st_req_queue #(
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned N_STB_ST_IN_PORT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           lsu_st_req_vld_i,
    input  logic                           lsu_st_req_is_fence_i,
    input  logic [3:0]                     lsu_st_req_rob_tag_i,
    input  logic [5:0]                     lsu_st_req_prd_i,
    input  logic [4:0]                     lsu_st_req_opcode_i,
    input  logic [55:0]                    lsu_st_req_paddr_i,
    input  logic [63:0]                    lsu_st_req_data_i,
    output logic                           lsu_st_req_rdy_o,
    output logic [N_STB_ST_IN_PORT-1:0]    st_req_vld_o,
    output logic [N_STB_ST_IN_PORT-1:0]    st_req_is_fence_o,
    output logic [N_STB_ST_IN_PORT*4-1:0]  st_req_rob_tag_o,
    output logic [N_STB_ST_IN_PORT*6-1:0]  st_req_prd_o,
    output logic [N_STB_ST_IN_PORT*5-1:0]  st_req_opcode_o,
    output logic [N_STB_ST_IN_PORT*56-1:0] st_req_paddr_o,
    output logic [N_STB_ST_IN_PORT*64-1:0] st_req_data_o,
    input  logic [N_STB_ST_IN_PORT-1:0]    st_req_rdy_i,
    output logic                           st_req_queue_empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        is_fence;
        logic [3:0]  rob_tag;
        logic [5:0]  prd;
        logic [4:0]  opcode;
        logic [55:0] paddr;
        logic [63:0] data;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_head1;
    entry_t           w_e0;
    entry_t           w_e1;
    logic             w_enq;
    logic             w_pop0;
    logic             w_pop1;

    // Fences and AMO/LR/SC (opcodes 7..28) must go out alone on port 0.
    function automatic logic is_special(input entry_t e);
        return e.is_fence | ((e.opcode >= 5'd7) & (e.opcode <= 5'd28));
    endfunction

    assign w_head1 = r_head + PTR_W'(1);
    assign w_e0    = r_mem[r_head];
    assign w_e1    = r_mem[w_head1];

    assign lsu_st_req_rdy_o     = (r_count != CNT_W'(DEPTH));
    assign st_req_queue_empty_o = (r_count == '0);
    assign w_enq                = lsu_st_req_vld_i & lsu_st_req_rdy_o;

    // Port 1 is gated on rdy[0] so it can only fire alongside port 0; this keeps
    // strict order and is loop-free since amo_ctrl rdy[0] ignores vld[1].
    assign st_req_vld_o[0] = (r_count >= CNT_W'(1));
    assign st_req_vld_o[1] = (r_count >= CNT_W'(2)) & ~is_special(w_e0) &
                             ~is_special(w_e1) & st_req_rdy_i[0];

    assign w_pop0 = st_req_vld_o[0] & st_req_rdy_i[0];
    assign w_pop1 = st_req_vld_o[1] & st_req_rdy_i[1] & w_pop0;

    assign st_req_is_fence_o = {w_e1.is_fence, w_e0.is_fence};
    assign st_req_rob_tag_o  = {w_e1.rob_tag,  w_e0.rob_tag};
    assign st_req_prd_o      = {w_e1.prd,      w_e0.prd};
    assign st_req_opcode_o   = {w_e1.opcode,   w_e0.opcode};
    assign st_req_paddr_o    = {w_e1.paddr,    w_e0.paddr};
    assign st_req_data_o     = {w_e1.data,     w_e0.data};

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop0) + PTR_W'(w_pop1);
            r_tail  <= r_tail + PTR_W'(w_enq);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop0) - CNT_W'(w_pop1);
        end
    end

    // Payload is not reset; a flushed enqueue is never written.
    always_ff @(posedge clk) begin
        if (w_enq && !flush_i && !rst) begin
            r_mem[r_tail] <= '{is_fence: lsu_st_req_is_fence_i,
                               rob_tag:  lsu_st_req_rob_tag_i,
                               prd:      lsu_st_req_prd_i,
                               opcode:   lsu_st_req_opcode_i,
                               paddr:    lsu_st_req_paddr_i,
                               data:     lsu_st_req_data_i};
        end
    end

endmodule
